// File: rtl/fsk_tone_detector.sv
// FSK tone detector: hysteretic rising-crossing detection, period measurement,
// mapping of the period to one of 16 tone indices, and confirmation over repeated periods.
module fsk_tone_detector #(
  parameter int SAMPLE_W = 12,
  parameter int HYST     = 64,
  parameter int P0       = 40,
  parameter int STEP     = 2,
  parameter int CONFIRM  = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] adc_in,
  output logic [3:0]                 data_out,
  output logic                       sym_valid,
  output logic                       locked,
  output logic                       period_err
);

  localparam logic signed [SAMPLE_W-1:0] HYST_POS = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] HYST_NEG = SAMPLE_W'(-HYST);
  localparam int                         HALF     = STEP / 2;
  localparam logic [2:0]                 CONF3    = 3'(CONFIRM);

  typedef enum logic {ARM, HIGH_WAIT} xstate_t;

  xstate_t    state, state_nxt;
  logic       rising;
  logic [7:0] cnt;
  logic       first;
  logic [2:0] mcnt, mcnt_bump;
  logic [3:0] cand;
  logic [8:0] period;
  logic       map_hit;
  logic [3:0] map_idx;
  logic       measure, timeout, confirm;

  always_ff @(posedge clk) begin
    if (reset) state <= ARM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rising    = 1'b0;
    if (sample_valid) begin
      case (state)
        ARM:       if (adc_in <= HYST_NEG) state_nxt = HIGH_WAIT;
        HIGH_WAIT: if (adc_in >= HYST_POS) begin
                     state_nxt = ARM;
                     rising    = 1'b1;
                   end
        default:   state_nxt = ARM;
      endcase
    end
  end

  // period = count before the crossing sample, plus one
  assign period = {1'b0, cnt} + 9'd1;

  // tone windows are contiguous and disjoint since STEP is even
  always_comb begin
    map_hit = 1'b0;
    map_idx = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (int'(period) > P0 - k*STEP - HALF && int'(period) <= P0 - k*STEP + HALF) begin
        map_hit = 1'b1;
        map_idx = 4'(k);
      end
    end
  end

  assign measure   = rising & ~first;
  assign timeout   = sample_valid & ~rising & ~first & (cnt == 8'hFF);
  assign mcnt_bump = (map_idx != cand) ? 3'd1 :
                     (mcnt < CONF3)    ? mcnt + 3'd1 : mcnt;
  assign confirm   = measure & map_hit & (mcnt_bump == CONF3);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= 8'd0;
      first      <= 1'b1;
      mcnt       <= 3'd0;
      cand       <= 4'd0;
      data_out   <= 4'd0;
      sym_valid  <= 1'b0;
      locked     <= 1'b0;
      period_err <= 1'b0;
    end else begin
      sym_valid  <= 1'b0;
      period_err <= 1'b0;
      if (sample_valid) begin
        if (rising)              cnt <= 8'd1;
        else if (cnt != 8'hFF)   cnt <= cnt + 8'd1;
        if (rising)              first <= 1'b0;
        if (measure) begin
          if (!map_hit) begin
            period_err <= 1'b1;
            mcnt       <= 3'd0;
          end else begin
            cand <= map_idx;
            mcnt <= mcnt_bump;
            if (confirm && (!locked || map_idx != data_out)) begin
              data_out  <= map_idx;
              sym_valid <= 1'b1;
              locked    <= 1'b1;
            end
          end
        end
        // no measurement in flight after a timeout, so it fires only once
        if (timeout) begin
          period_err <= 1'b1;
          locked     <= 1'b0;
          mcnt       <= 3'd0;
          first      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fsk_tone_detector.sv
// Randomized bench for fsk_tone_detector: directed tone scenarios plus random
// segments, every cycle compared against a sample-level behavioural model.
module tb_fsk_tone_detector;

  localparam int SAMPLE_W = 12;
  localparam int HYST     = 64;
  localparam int P0       = 40;
  localparam int STEP     = 2;
  localparam int CONFIRM  = 3;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       sample_valid = 1'b0;
  logic signed [SAMPLE_W-1:0] adc_in = '0;
  logic [3:0]                 data_out;
  logic                       sym_valid, locked, period_err;

  fsk_tone_detector #(.SAMPLE_W(SAMPLE_W), .HYST(HYST), .P0(P0), .STEP(STEP), .CONFIRM(CONFIRM)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .adc_in(adc_in),
    .data_out(data_out), .sym_valid(sym_valid), .locked(locked), .period_err(period_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int gap_pct = 0;
  int noise = 0;

  // model state: "high" means a -HYST excursion has been seen since the last crossing
  bit m_high, m_first;
  int m_since, m_cnt, m_cand;
  int e_data;
  bit e_sv, e_lock, e_pe;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tone_of(input int p);
    tone_of = -1;
    for (int k = 0; k < 16; k++)
      if (p > P0 - k*STEP - STEP/2 && p <= P0 - k*STEP + STEP/2) tone_of = k;
  endfunction

  task automatic model_step(input bit rst, input bit v, input int s);
    bit rise;
    int k;
    if (rst) begin
      m_high = 0; m_first = 1; m_since = 0; m_cnt = 0; m_cand = 0;
      e_data = 0; e_sv = 0; e_lock = 0; e_pe = 0;
      return;
    end
    e_sv = 0; e_pe = 0;
    if (!v) return;
    rise = 0;
    if (!m_high) begin
      if (s <= -HYST) m_high = 1;
    end else if (s >= HYST) begin
      m_high = 0; rise = 1;
    end
    if (rise) begin
      if (m_first) m_first = 0;
      else begin
        k = tone_of(m_since + 1);
        if (k < 0) begin
          e_pe = 1; m_cnt = 0;
        end else begin
          if (k == m_cand) m_cnt = (m_cnt + 1 > CONFIRM) ? CONFIRM : m_cnt + 1;
          else begin m_cand = k; m_cnt = 1; end
          if (m_cnt == CONFIRM && (!e_lock || m_cand != e_data)) begin
            e_data = m_cand; e_sv = 1; e_lock = 1;
          end
        end
      end
      m_since = 1;
    end else begin
      if (m_since >= 255 && !m_first) begin
        e_pe = 1; e_lock = 0; m_cnt = 0; m_first = 1;
      end
      m_since++;
    end
  endtask

  task automatic cycle(input bit rst, input bit v, input int s);
    @(negedge clk);
    reset = rst; sample_valid = v; adc_in = SAMPLE_W'(s);
    @(posedge clk);
    model_step(rst, v, s);
    #1;
    chk("data_out", data_out, e_data);
    chk("sym_valid", sym_valid, e_sv);
    chk("locked", locked, e_lock);
    chk("period_err", period_err, e_pe);
  endtask

  task automatic samp(input int s);
    while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct)
      cycle(1'b0, 1'b0, int'($urandom_range(4000, 0)) - 2000);
    cycle(1'b0, 1'b1, s + (noise > 0 ? int'($urandom_range(2*noise, 0)) - noise : 0));
  endtask

  task automatic square(input int per, input int n, input int amp);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < per/2; j++)   samp(-amp);
      for (int j = per/2; j < per; j++) samp(amp);
    end
  endtask

  task automatic sine(input int per, input int n, input int amp);
    for (int i = 0; i < n*per; i++)
      samp(int'($rtoi(amp * $sin(6.283185307 * i / per))));
  endtask

  initial begin
    int per, amp;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1000);

    square(40, 5, 1000);
    chk("p40_data", data_out, 0);
    chk("p40_locked", locked, 1);

    square(10, 5, 1000);
    chk("p10_data", data_out, 15);

    noise = 50;
    sine(24, 6, 1000);
    noise = 0;
    chk("sine24_data", data_out, 8);

    square(60, 1, 1000);
    chk("p60_locked", locked, 1);
    chk("p60_data", data_out, 8);

    square(40, 5, 1000);
    for (int i = 0; i < 300; i++) samp(0);
    chk("hold_locked", locked, 0);
    chk("hold_data", data_out, 0);

    square(40, 2, 1000);
    for (int j = 0; j < 13; j++) samp(-1000);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, -1000);
    square(20, 5, 1000);
    chk("rst_p20_data", data_out, 10);
    chk("rst_p20_locked", locked, 1);

    // random segments: tone or off-grid periods, noise, gaps, occasional reset
    for (int seg = 0; seg < 40; seg++) begin
      gap_pct = $urandom_range(3, 0) * 10;
      noise   = $urandom_range(60, 0);
      amp     = $urandom_range(1900, 150);
      case ($urandom_range(5, 0))
        0:       per = 60;
        1:       per = 2 * $urandom_range(22, 4);
        default: per = P0 - STEP * $urandom_range(15, 0);
      endcase
      if ($urandom_range(19, 0) == 0)
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 0);
      if ($urandom_range(1, 0) == 0) square(per, $urandom_range(6, 1), amp);
      else                           sine(per, $urandom_range(6, 1), amp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
